// File: rtl/adaptive_threshold.sv
// Frame-statistics driven threshold controller for a 1-bit dithering stage.
// Counts transitions and white pixels per frame, then nudges the threshold once per frame.
module adaptive_threshold #(
    parameter int H_PIXELS  = 320,
    parameter int V_PIXELS  = 240,
    parameter int TH_WIDTH  = 8,
    parameter int TH_RESET  = 60,
    parameter int TH_MIN    = 5,
    parameter int TH_MAX    = 250,
    parameter int STEP      = 5,
    parameter int CNT_WIDTH = $clog2(H_PIXELS*V_PIXELS+1)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 dithered_pixel,
    input  logic                 dithered_valid,
    input  logic                 mode,
    input  logic                 freeze,
    input  logic [CNT_WIDTH-1:0] target_ones,
    input  logic [CNT_WIDTH-1:0] deadband,
    input  logic [TH_WIDTH-1:0]  threshold_in,
    input  logic                 threshold_load,
    output logic [TH_WIDTH-1:0]  threshold_out,
    output logic                 frame_done,
    output logic [CNT_WIDTH-1:0] frame_transitions,
    output logic [CNT_WIDTH-1:0] frame_ones,
    output logic                 direction
);

    localparam int COL_W = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int ROW_W = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;

    localparam logic [TH_WIDTH-1:0] TH_RESET_T = TH_WIDTH'(TH_RESET);
    localparam logic [TH_WIDTH-1:0] TH_MIN_T   = TH_WIDTH'(TH_MIN);
    localparam logic [TH_WIDTH-1:0] TH_MAX_T   = TH_WIDTH'(TH_MAX);
    localparam logic [TH_WIDTH:0]   STEP_X     = (TH_WIDTH+1)'(STEP);
    localparam logic [TH_WIDTH:0]   TH_MAX_X   = (TH_WIDTH+1)'(TH_MAX);
    localparam logic [TH_WIDTH:0]   DN_FLOOR_X = (TH_WIDTH+1)'(TH_MIN + STEP);

    typedef enum logic [1:0] {ACCUM, EVAL, APPLY} state_t;
    typedef enum logic [1:0] {DEC_HOLD, DEC_UP, DEC_DOWN} dec_t;

    state_t               state_q;
    dec_t                 dec_q;
    logic [COL_W-1:0]     col_q;
    logic [ROW_W-1:0]     row_q;
    logic                 prev_pix_q;
    logic [CNT_WIDTH-1:0] trans_q, ones_q;
    logic [CNT_WIDTH-1:0] frame_trans_q, frame_ones_q, prev_trans_q;
    logic                 prev_valid_q, dir_q, frame_done_q, mode_q;
    logic [TH_WIDTH-1:0]  th_q;

    logic                 last_col, last_row, last_pix, is_trans, is_one;
    logic [CNT_WIDTH-1:0] trans_d, ones_d;
    logic                 mode_changed, flip, dir_d;
    logic [CNT_WIDTH:0]   ones_x, tgt_x, hi_x, lo_x;
    dec_t                 density_dec;
    logic [TH_WIDTH:0]    th_x, th_up_x;
    logic [TH_WIDTH-1:0]  th_up_d, th_dn_d, th_load_d;

    always_comb begin
        last_col = (col_q == COL_W'(H_PIXELS - 1));
        last_row = (row_q == ROW_W'(V_PIXELS - 1));
        last_pix = dithered_valid && last_col && last_row;
        // Column 0 never counts, so no transition is seen across a row boundary.
        is_trans = dithered_valid && (col_q != '0) && (dithered_pixel != prev_pix_q);
        is_one   = dithered_valid && dithered_pixel;
        trans_d  = trans_q + CNT_WIDTH'(is_trans);
        ones_d   = ones_q + CNT_WIDTH'(is_one);

        mode_changed = (mode != mode_q);
        flip  = prev_valid_q && !mode_changed && (frame_trans_q < prev_trans_q);
        dir_d = dir_q ^ flip;

        ones_x = {1'b0, frame_ones_q};
        tgt_x  = {1'b0, target_ones};
        hi_x   = tgt_x + {1'b0, deadband};
        lo_x   = ones_x + {1'b0, deadband};
        if (ones_x > hi_x)      density_dec = DEC_UP;
        else if (lo_x < tgt_x)  density_dec = DEC_DOWN;
        else                    density_dec = DEC_HOLD;

        th_x    = {1'b0, th_q};
        th_up_x = th_x + STEP_X;
        th_up_d = (th_up_x > TH_MAX_X) ? TH_MAX_T : th_up_x[TH_WIDTH-1:0];
        th_dn_d = (th_x < DN_FLOOR_X) ? TH_MIN_T : th_q - STEP_X[TH_WIDTH-1:0];

        if (threshold_in < TH_MIN_T)       th_load_d = TH_MIN_T;
        else if (threshold_in > TH_MAX_T)  th_load_d = TH_MAX_T;
        else                               th_load_d = threshold_in;
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the later th_q assignment from threshold_load wins by order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= ACCUM;
            dec_q         <= DEC_HOLD;
            col_q         <= '0;
            row_q         <= '0;
            prev_pix_q    <= 1'b0;
            trans_q       <= '0;
            ones_q        <= '0;
            frame_trans_q <= '0;
            frame_ones_q  <= '0;
            prev_trans_q  <= '0;
            prev_valid_q  <= 1'b0;
            dir_q         <= 1'b1;
            frame_done_q  <= 1'b0;
            mode_q        <= mode;
            th_q          <= TH_RESET_T;
        end else begin
            mode_q       <= mode;
            frame_done_q <= (state_q == EVAL);

            if (dithered_valid) begin
                prev_pix_q <= dithered_pixel;
                if (last_col) begin
                    col_q <= '0;
                    row_q <= last_row ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end

            if (last_pix) begin
                frame_trans_q <= trans_d;
                frame_ones_q  <= ones_d;
                trans_q       <= '0;
                ones_q        <= '0;
            end else begin
                trans_q <= trans_d;
                ones_q  <= ones_d;
            end

            if (mode_changed) prev_valid_q <= 1'b0;

            case (state_q)
                ACCUM: if (last_pix) state_q <= EVAL;
                EVAL: begin
                    state_q <= APPLY;
                    if (!mode) begin
                        dir_q        <= dir_d;
                        prev_trans_q <= frame_trans_q;
                        prev_valid_q <= 1'b1;
                        dec_q        <= dir_d ? DEC_UP : DEC_DOWN;
                    end else begin
                        dec_q <= density_dec;
                    end
                end
                APPLY: begin
                    state_q <= ACCUM;
                    if (!freeze) begin
                        if (dec_q == DEC_UP)        th_q <= th_up_d;
                        else if (dec_q == DEC_DOWN) th_q <= th_dn_d;
                    end
                end
                default: state_q <= ACCUM;
            endcase

            if (threshold_load) th_q <= th_load_d;
        end
    end

    assign threshold_out     = th_q;
    assign frame_done        = frame_done_q;
    assign frame_transitions = frame_trans_q;
    assign frame_ones        = frame_ones_q;
    assign direction         = dir_q;

endmodule

// File: doc/adaptive_threshold.md
ADAPTIVE_THRESHOLD -- requirements
Module: adaptive_threshold

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 H_PIXELS, 320, pixels per row
 V_PIXELS, 240, rows per frame
 TH_WIDTH, 8, threshold width
 TH_RESET, 60, threshold after reset
 TH_MIN, 5, lower clamp
 TH_MAX, 250, upper clamp
 STEP, 5, per-frame adjustment
 CNT_WIDTH, $clog2(H_PIXELS*V_PIXELS+1), statistic counter width
REQ-002 Ports (name, direction, width, meaning), one per line:
 clk_in, input, 1, sole clock
 rst_in, input, 1, synchronous active-high reset
 dithered_pixel, input, 1, dithered output bit (1 = white)
 dithered_valid, input, 1, pixel strobe, raster order
 mode, input, 1, 0 = hill-climb on transitions, 1 = density tracking
 freeze, input, 1, hold threshold, statistics still update
 target_ones, input, CNT_WIDTH, density-mode target white count per frame
 deadband, input, CNT_WIDTH, density-mode tolerance
 threshold_in, input, TH_WIDTH, override value
 threshold_load, input, 1, override strobe
 threshold_out, output, TH_WIDTH, active threshold
 frame_done, output, 1, one-cycle pulse on update cycle
 frame_transitions, output, CNT_WIDTH, transitions in last completed frame
 frame_ones, output, CNT_WIDTH, white pixels in last completed frame
 direction, output, 1, hill-climb direction (1 = increase)
REQ-003 Single clock domain: clk_in; reset rst_in, synchronous, active-high.

Function
REQ-004 Column counter (0..H_PIXELS-1) and row counter (0..V_PIXELS-1) advance only on dithered_valid; column wraps to 0 and increments row; row wraps to 0 at frame end.
REQ-005 Transition counted when dithered_valid, column != 0, and dithered_pixel != previous valid pixel; first pixel of each row never counts (no cross-row transitions).
REQ-006 Ones counter increments on each valid pixel with dithered_pixel = 1.
REQ-007 On the valid of the last pixel (col = H_PIXELS-1, row = V_PIXELS-1): snapshot both counts into frame_transitions/frame_ones including that pixel; running counters restart at 0 that cycle; FSM ACCUM -> EVAL.
REQ-008 FSM states ACCUM, EVAL, APPLY; EVAL and APPLY each last exactly one cycle; APPLY -> ACCUM; pixels arriving in EVAL/APPLY accumulate into the next frame.
REQ-009 EVAL, mode 0: if prev_valid and frame_transitions < previous frame's count, invert direction; store count as previous; set prev_valid.
REQ-010 EVAL, mode 1: decision = increase if frame_ones > target_ones + deadband, decrease if frame_ones + deadband < target_ones, else hold; direction unchanged; sums computed at CNT_WIDTH+1 bits.
REQ-011 APPLY: frame_done = 1; unless freeze, threshold_out moves STEP in the decided direction (mode 0 always moves), saturating at TH_MIN/TH_MAX, with arithmetic at TH_WIDTH+1 bits.
REQ-012 threshold_out therefore changes two cycles after the last pixel's valid cycle.
REQ-013 threshold_load: threshold_out <= threshold_in clamped to [TH_MIN, TH_MAX] next cycle; takes priority over an APPLY update in the same cycle; FSM and statistics unaffected.
REQ-014 A mode change takes effect at the next EVAL; prev_valid clears on any mode change.
REQ-015 Counters never wrap within a frame (CNT_WIDTH covers H_PIXELS*V_PIXELS).

Reset
REQ-016 On rst_in: threshold_out = TH_RESET, direction = 1, frame_done = 0, frame_transitions = frame_ones = 0, counters/row/col = 0, prev_valid = 0, FSM = ACCUM.
REQ-017 Reset mid-frame discards the partial frame; next valid pixel is col 0, row 0.

Verification (H_PIXELS=4, V_PIXELS=2, STEP=5 unless stated)
REQ-018 Mode 0, frame 1010/1010 -> frame_transitions = 6 (no row-crossing count), frame_ones = 4, threshold 60 -> 65 two cycles after pixel 8, frame_done single pulse.
REQ-019 Mode 0, frame 1 = 6 transitions then frame 2 = 2 -> direction flips to 0, threshold 65 -> 60.
REQ-020 Mode 1, target_ones = 2, deadband = 0, all-white frame -> threshold +5; all-black frame -> -5; exactly 2 ones -> hold.
REQ-021 Threshold at 248 increasing -> 250; at 7 decreasing -> 5; threshold_in = 255 load -> 250.
REQ-022 threshold_load asserted in APPLY cycle with threshold_in = 100 -> threshold_out = 100; freeze = 1 -> threshold unchanged, frame_done and statistics still update.
REQ-023 rst_in after 5 pixels -> all outputs at REQ-016 values; next full frame counts only post-reset pixels.
